// File: rtl/multicycle_control.sv
// Control unit for a multicycle MIPS-style datapath.
// A 4-bit state register drives combinational datapath selects and strobes.
// Inputs : clk, reset (async, active-high), Op, Funct, zero (ALU zero flag).
// Outputs: ALU_Control, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite,
//          RegWrite, RegDst, MemtoReg, PCEn, illegal_op, state (debug).
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       zero,
  output logic [2:0] ALU_Control,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       PCEn,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam int unsigned STATE_W = 4;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] alu_op;
  logic       pc_write;
  logic       branch;
  logic       ir_write;

  // State register; reset forces FETCH without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d    = S_FETCH;
    alu_op     = ALUOP_ADD;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB  = 2'b01;
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ALU decoder; unknown R-type functs select 011 so the ALU yields 0.
  always_comb begin
    ALU_Control = 3'b010;
    case (alu_op)
      ALUOP_ADD: ALU_Control = 3'b010;
      ALUOP_SUB: ALU_Control = 3'b110;
      ALUOP_FUNCT: begin
        case (Funct)
          6'b100000: ALU_Control = 3'b010;
          6'b100010: ALU_Control = 3'b110;
          6'b100100: ALU_Control = 3'b000;
          6'b100101: ALU_Control = 3'b001;
          6'b101010: ALU_Control = 3'b111;
          default:   ALU_Control = 3'b011;
        endcase
      end
      default: ALU_Control = 3'b010;
    endcase
  end

  // Reset holds FETCH selects but suppresses its write strobes.
  assign IRWrite = ir_write & ~reset;
  assign PCEn    = (pc_write | (branch & zero)) & ~reset;
  assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       zero;
  logic [2:0] ALU_Control;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCEn, illegal_op;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       irw;
    logic       memw;
    logic       regw;
    logic       regdst;
    logic       m2r;
    logic       pcen;
    logic       ill;
  } obs_t;

  obs_t obs;
  assign obs = {state, ALU_Control, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite,
                MemWrite, RegWrite, RegDst, MemtoReg, PCEn, illegal_op};

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .zero(zero),
    .ALU_Control(ALU_Control), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .PCEn(PCEn),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Sequence of states an instruction walks through, from its opcode class.
  function automatic void instr_path(input logic [5:0] op, output int path[$]);
    case (op)
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000000: path = '{0, 1, 6, 7};
      6'b000100: path = '{0, 1, 8};
      6'b001000: path = '{0, 1, 9, 10};
      6'b000010: path = '{0, 1, 11};
      default:   path = '{0, 1};
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b011;
    endcase
  endfunction

  // Expected outputs of one cycle spent in state s.
  function automatic obs_t expect_cycle(input int s, input logic [5:0] op,
                                        input logic [5:0] f, input logic z);
    obs_t e;
    e = '0;
    e.st  = 4'(s);
    e.alu = 3'b010;
    case (s)
      0:  begin e.srcb = 2'b01; e.irw = 1'b1; e.pcen = 1'b1; end
      1:  begin e.srcb = 2'b11; e.ill = !is_legal(op); end
      2:  begin e.srca = 1'b1; e.srcb = 2'b10; end
      3:  e.iord = 1'b1;
      4:  begin e.m2r = 1'b1; e.regw = 1'b1; end
      5:  begin e.iord = 1'b1; e.memw = 1'b1; end
      6:  begin e.srca = 1'b1; e.alu = funct_alu(f); end
      7:  begin e.regdst = 1'b1; e.regw = 1'b1; end
      8:  begin e.srca = 1'b1; e.alu = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
      9:  begin e.srca = 1'b1; e.srcb = 2'b10; end
      10: e.regw = 1'b1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t reset_values();
    obs_t e;
    e = '0;
    e.alu  = 3'b010;
    e.srcb = 2'b01;
    return e;
  endfunction

  task automatic check(input string tag, input obs_t exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Runs one instruction; zsel 0/1 forces zero, 2 randomizes it each cycle.
  // ncyc > 0 stops after that many cycles (used to abort mid-instruction).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                           input int zsel, input int ncyc);
    int path[$];
    instr_path(op, path);
    foreach (path[i]) begin
      if (ncyc > 0 && i >= ncyc) break;
      @(negedge clk);
      if (i == 0) begin
        Op    = op;
        Funct = f;
      end
      zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      #1;
      check($sformatf("op%b_f%b_cyc%0d", op, f, i), expect_cycle(path[i], op, f, zero));
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] f;
    logic [5:0] legal_ops [6];
    logic [5:0] functs [5];
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    functs    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b1;
    Op    = '0;
    Funct = '0;
    zero  = 1'b0;
    #3;
    check("reset_initial", reset_values());
    @(posedge clk);
    #1;
    check("reset_held_edge", reset_values());
    #2 reset = 1'b0;

    // Directed: lw, slt, beq taken/not taken, illegal, unknown funct.
    run_instr(6'b100011, 6'b000000, 2, 0);
    run_instr(6'b000000, 6'b101010, 2, 0);
    run_instr(6'b000100, 6'b000000, 1, 0);
    run_instr(6'b000100, 6'b000000, 0, 0);
    run_instr(6'b111111, 6'b000000, 2, 0);
    run_instr(6'b000000, 6'b000000, 2, 0);
    run_instr(6'b101011, 6'b000000, 2, 0);
    run_instr(6'b001000, 6'b000000, 2, 0);
    run_instr(6'b000010, 6'b000000, 2, 0);
    run_instr(6'b100011, 6'b000000, 2, 0);

    // Asynchronous reset in the middle of MEMWR.
    run_instr(6'b101011, 6'b000000, 2, 3);
    @(negedge clk);
    #1;
    check("memwr_before_reset", expect_cycle(5, 6'b101011, 6'b000000, zero));
    #1 reset = 1'b1;
    #1;
    check("memwr_async_reset", reset_values());
    @(posedge clk);
    #1;
    check("memwr_reset_held", reset_values());
    #2 reset = 1'b0;
    run_instr(6'b000000, 6'b100101, 2, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom);
        if (is_legal(op)) op = 6'b111111;
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else                            f = functs[$urandom_range(0, 4)];
      run_instr(op, f, 2, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed by this document.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Op  input  6  instruction opcode field (instr[31:26]).
REQ-005 Funct  input  6  instruction function field (instr[5:0]).
REQ-006 zero  input  1  ALU zero flag, same cycle.
REQ-007 ALU_Control  output  3  ALU operation: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
REQ-008 ALUSrcA  output  1  0 = PC, 1 = register A.
REQ-009 ALUSrcB  output  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-010 PCSrc  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-011 IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCEn  outputs  1 each  standard multicycle datapath strobes and selects.
REQ-012 illegal_op  output  1  high in DECODE when Op is unrecognised.
REQ-013 state  output  4  current state encoding, for debug.

Function
REQ-014 The block SHALL be a Moore FSM: a 4-bit state register plus combinational output and next-state logic; every output SHALL depend only on state, except ALU_Control (state, Funct), PCEn (state, zero) and illegal_op (state, Op).
REQ-015 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-016 Every output not listed for a state SHALL be 0; ALUOp is internal (00 add, 01 sub, 10 funct).
REQ-017 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1 -> DECODE.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, any other value -> FETCH with illegal_op=1.
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Op 100011 -> MEMRD, otherwise -> MEMWR.
REQ-020 MEMRD: IorD=1 -> MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
REQ-021 MEMWR: IorD=1, MemWrite=1 -> FETCH.
REQ-022 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB. ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
REQ-024 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-025 JUMP: PCSrc=10, PCWrite=1 -> FETCH.
REQ-026 PCEn SHALL equal PCWrite OR (Branch AND zero), combinationally.
REQ-027 ALU_Control: ALUOp 00 -> 010; 01 -> 110; 10 -> by Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other -> 011 (ALU yields 0).
REQ-028 Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.

Reset
REQ-029 reset high SHALL force state to FETCH immediately, without waiting for a clock edge.
REQ-030 While reset is high, IRWrite, PCWrite, PCEn, MemWrite and RegWrite SHALL be 0; all other outputs SHALL take FETCH values (ALU_Control=010).
REQ-031 Reset asserted mid-instruction SHALL abort it with no further write strobes; the first edge after reset release SHALL execute FETCH.

Verification
REQ-032 Release reset, Op=100011 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; IorD=1 in states 3,4? no: only in state 3.
REQ-033 R-type Funct=101010 -> in EXECUTE ALU_Control=111; ALUWB RegDst=1, RegWrite=1; back in FETCH at cycle 5.
REQ-034 beq with zero=1 in BRANCH -> PCEn=1, PCSrc=01; repeat with zero=0 -> PCEn=0; both return to FETCH.
REQ-035 Op=111111 -> DECODE asserts illegal_op=1, next state FETCH, no RegWrite or MemWrite asserted.
REQ-036 Assert reset asynchronously during MEMWR (mid-cycle) -> state=0 and MemWrite=0 before the next clock edge.
REQ-037 R-type Funct=000000 in EXECUTE -> ALU_Control=011.
